// File: rtl/exu_div.sv
// exu_div: radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and *W ops.
// Divide-by-zero and signed overflow bypass the iteration and complete one cycle after accept.
module exu_div #(
   parameter int W = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   input  logic         i_signed,
   input  logic         i_rem,
   input  logic         i_word,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_res
);

   localparam int H  = W / 2;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic [W-1:0]    res_q, res_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            op_rem_q, op_rem_d;
   logic            op_word_q, op_word_d;

   // Sign fix, quotient/remainder selection and word sign-extension of the final value.
   function automatic logic [W-1:0] finish_res(input logic [W-1:0] quo, input logic [W-1:0] rem,
                                               input logic neg_q, input logic neg_r,
                                               input logic sel_rem, input logic word);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] sel;
      q   = neg_q ? -quo : quo;
      r   = neg_r ? -rem : rem;
      sel = sel_rem ? r : q;
      return word ? {{H{sel[H-1]}}, sel[H-1:0]} : sel;
   endfunction

   logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_ext;
   logic         a_neg, b_neg, div_zero, ovf;
   logic [W:0]   shl, trial;
   logic [W-1:0] rem_nx, quo_nx;

   always_comb begin
      a_ext = i_word ? (i_signed ? {{H{i_dividend[H-1]}}, i_dividend[H-1:0]}
                                 : {{H{1'b0}}, i_dividend[H-1:0]}) : i_dividend;
      b_ext = i_word ? (i_signed ? {{H{i_divisor[H-1]}}, i_divisor[H-1:0]}
                                 : {{H{1'b0}}, i_divisor[H-1:0]}) : i_divisor;
      a_neg = i_signed & a_ext[W-1];
      b_neg = i_signed & b_ext[W-1];
      a_mag = a_neg ? -a_ext : a_ext;
      b_mag = b_neg ? -b_ext : b_ext;
      min_ext  = i_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
      div_zero = (b_ext == '0);
      ovf      = i_signed && (a_ext == min_ext) && (b_ext == '1);
   end

   // rem < divisor < 2^W, so a W+1-bit difference keeps its sign in the top bit.
   always_comb begin
      shl   = {rem_q, quo_q[W-1]};
      trial = shl - {1'b0, dvs_q};
      if (!trial[W]) begin
         rem_nx = trial[W-1:0];
         quo_nx = {quo_q[W-2:0], 1'b1};
      end else begin
         rem_nx = shl[W-1:0];
         quo_nx = {quo_q[W-2:0], 1'b0};
      end
   end

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      res_d     = res_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      op_rem_d  = op_rem_q;
      op_word_d = op_word_q;

      if (i_flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (i_valid) begin
               op_rem_d  = i_rem;
               op_word_d = i_word;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dvs_d     = b_mag;
               if (div_zero) begin
                  res_d   = finish_res('1, a_ext, 1'b0, 1'b0, i_rem, i_word);
                  state_d = DONE;
               end else if (ovf) begin
                  res_d   = finish_res(a_ext, '0, 1'b0, 1'b0, i_rem, i_word);
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = i_word ? {a_mag[H-1:0], {H{1'b0}}} : a_mag;
                  cnt_d   = i_word ? CW'(H - 1) : CW'(W - 1);
                  state_d = CALC;
               end
            end
            CALC: begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               if (cnt_q == '0) begin
                  res_d   = finish_res(quo_nx, rem_nx, neg_quo_q, neg_rem_q, op_rem_q, op_word_q);
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         res_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         op_rem_q  <= 1'b0;
         op_word_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         res_q     <= res_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         op_rem_q  <= op_rem_d;
         op_word_q <= op_word_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_res   = res_q;

endmodule

// File: tb/tb_exu_div.sv
// Directed and randomised checks of exu_div (W=64): results, latency, stall, flush and reset.
module tb_exu_div;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [63:0] i_dividend = '0;
   logic [63:0] i_divisor = '0;
   logic        i_signed = 1'b0;
   logic        i_rem = 1'b0;
   logic        i_word = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [63:0] o_res;

   int n_total = 0;
   int n_bad   = 0;

   exu_div #(.W(64)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
      .i_dividend(i_dividend), .i_divisor(i_divisor), .i_signed(i_signed), .i_rem(i_rem),
      .i_word(i_word), .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) assert (!(o_ready && o_valid)) else $error("ready and valid both high");

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics, written directly from the ISA definition.
   function automatic logic [63:0] ref_div(input bit s, input bit r, input bit w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, res32;
      int          sa32, sb32;
      longint      sa, sb;
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         sa32 = a32;
         sb32 = b32;
         if (b32 == 0)                                       res32 = r ? a32 : 32'hFFFF_FFFF;
         else if (s && a32 == 32'h8000_0000 && b32 == '1)    res32 = r ? 32'd0 : a32;
         else if (s)                                         res32 = r ? sa32 % sb32 : sa32 / sb32;
         else                                                res32 = r ? a32 % b32 : a32 / b32;
         return {{32{res32[31]}}, res32};
      end
      sa = a;
      sb = b;
      if (b == 0)                                            return r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      if (s && a == 64'h8000_0000_0000_0000 && b == '1)      return r ? 64'd0 : a;
      if (s)                                                 return r ? sa % sb : sa / sb;
      return r ? a % b : a / b;
   endfunction

   task automatic start_op(input bit s, input bit r, input bit w,
                           input logic [63:0] a, input logic [63:0] b);
      i_signed = s; i_rem = r; i_word = w; i_dividend = a; i_divisor = b; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_dividend = {$urandom, $urandom};
      i_divisor  = {$urandom, $urandom};
      i_signed = $urandom_range(0, 1); i_rem = $urandom_range(0, 1); i_word = $urandom_range(0, 1);
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!o_valid && lat < 200) begin
         @(posedge i_clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input bit s, input bit r, input bit w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int exp_lat, input int hold);
      int lat;
      start_op(s, r, w, a, b);
      wait_valid(lat);
      if (exp_lat != 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      else              check({tag, "_vld"}, {63'd0, o_valid}, 64'd1);
      check(tag, o_res, exp);
      for (int k = 0; k < hold; k++) begin
         @(posedge i_clk); #1;
         check({tag, "_hold"}, {o_valid, o_res[62:0]}, {1'b1, exp[62:0]});
      end
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      check({tag, "_idle"}, {62'd0, o_ready, o_valid}, 64'd2);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 4))
         0:       return 64'd0;
         1:       return '1;
         2:       return {$urandom, $urandom};
         3:       return 64'($urandom_range(1, 20));
         default: return $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
      endcase
   endfunction

   initial begin
      int lat;
      logic [63:0] a, b;
      bit s, r, w;

      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      check("rst_ready", {63'd0, o_ready}, 64'd1);
      check("rst_valid", {63'd0, o_valid}, 64'd0);
      check("rst_res", o_res, 64'd0);

      run_op("divu_100_7", 0, 0, 0, 64'd100, 64'd7, 64'd14, 65, 5);
      run_op("remu_100_7", 0, 1, 0, 64'd100, 64'd7, 64'd2, 65, 0);
      run_op("div_m7_2", 1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
      run_op("rem_m7_2", 1, 1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      run_op("rem_7_m2", 1, 1, 0, 64'd7, -64'sd2, 64'd1, 65, 0);
      run_op("div_5_0", 1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      run_op("remu_1234_0", 0, 1, 0, 64'h1234, 64'd0, 64'h1234, 1, 2);
      run_op("div_ovf", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
      run_op("remw_ovf", 1, 1, 1, 64'h8000_0000, '1, 64'd0, 1, 0);
      run_op("divw_ovf", 1, 0, 1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
      run_op("divuw_ff_1", 0, 0, 1, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0001,
             64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
      run_op("remw_9_4", 1, 1, 1, 64'h1_0000_0009, 64'd4, 64'd1, 33, 0);

      // Flush during CALC: abort at T+10, idle at T+11, no result afterwards.
      start_op(0, 0, 0, 64'd1000, 64'd3);
      repeat (9) begin @(posedge i_clk); #1; end
      check("flush_busy", {63'd0, o_ready}, 64'd0);
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      check("flush_idle", {62'd0, o_ready, o_valid}, 64'd2);
      lat = 0;
      for (int k = 0; k < 70; k++) begin
         @(posedge i_clk); #1;
         if (o_valid) lat++;
      end
      check("flush_noval", 64'(lat), 64'd0);

      // A request presented together with flush is ignored.
      i_valid = 1'b1; i_flush = 1'b1; i_signed = 1'b0; i_rem = 1'b0; i_word = 1'b0;
      i_dividend = 64'd5; i_divisor = 64'd0;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_flush = 1'b0;
      @(posedge i_clk); #1;
      check("flush_req", {62'd0, o_ready, o_valid}, 64'd2);

      // Async reset while a result is waiting in DONE.
      start_op(0, 0, 0, 64'd100, 64'd7);
      wait_valid(lat);
      check("pre_rst_vld", {63'd0, o_valid}, 64'd1);
      #2 i_rst = 1'b1;
      #1;
      check("arst_out", {o_ready, o_valid, o_res[61:0]}, 64'h8000_0000_0000_0000);
      @(posedge i_clk); #1 i_rst = 1'b0;
      run_op("divu_9_3", 0, 0, 0, 64'd9, 64'd3, 64'd3, 65, 0);

      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
         a = pick();
         b = pick();
         run_op($sformatf("rnd%0d_s%0d_r%0d_w%0d", i, s, r, w), s, r, w, a, b,
                ref_div(s, r, w, a, b), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
